rs_ccff_chain: RTL
==================

Name: rs_ccff_chain

Overview:
Parametrised configuration-chain segment, successor to the single-bit configuration-chain flip-flop. Holds WIDTH configuration bits in a serial shift chain, with a bit counter, an optional even-parity check, and a shadow register committed atomically, so the datapath never sees partially shifted bits. A rotate-readback mode lets the bits be read out non-destructively. MEM/MEMB drive the fabric datapath, gated by CFG_EN exactly like the single-bit cell.

Parameters:
WIDTH, 8, number of configuration bits in the segment (>=2)
PARITY, 1, 1 = one trailing even-parity bit per load session; 0 = none
CNT_W, $clog2(WIDTH+2), width of the bit counter (derived; do not override)

Ports:
CK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
CFG_EN  input  1  0 = configuration mode (MEM forced 0); 1 = MEM follows shadow
D  input  1  serial configuration data in
SHIFT_EN  input  1  one chain shift per cycle when high
MODE  input  1  0 = load from D; 1 = rotate readback (tail feeds head)
COMMIT  input  1  copy chain into shadow when the load is complete and checked
CLR  input  1  abort the load session: counter, parity and state cleared; shadow kept
Q  output  1  chain tail chain[WIDTH-1], for daisy-chaining
MEM  output  WIDTH  shadow & {WIDTH{CFG_EN}} (combinational)
MEMB  output  WIDTH  ~MEM
BIT_CNT  output  CNT_W  bits accepted in the current load session
DONE  output  1  state == READY
ERR  output  1  state == ERROR

Behaviour:
- Reset: chain=0, shadow=0, BIT_CNT=0, parity accumulator=0, state=IDLE. Consequently Q=0, MEM=0, MEMB=all ones, DONE=0, ERR=0.
- Priority per cycle: RST > CLR > COMMIT > SHIFT_EN.
- States: IDLE, LOADING, READY, ERROR.
- Load shift (SHIFT_EN=1, MODE=0, state IDLE/LOADING):
  - While BIT_CNT<WIDTH: chain <= {chain[WIDTH-2:0], D}; parity ^= D; BIT_CNT+1; state=LOADING.
  - Data is MSB first: after WIDTH shifts the first bit sits in chain[WIDTH-1].
  - When BIT_CNT==WIDTH and PARITY=1: D is the parity bit. Chain is not shifted; BIT_CNT=WIDTH+1.
  - Transition to READY if (parity^D)==0, else ERROR.
  - PARITY=0: the WIDTH-th shift moves the state directly to READY.
- SHIFT_EN with MODE=0 in READY: overrun. Chain unchanged; state -> ERROR.
- SHIFT_EN in ERROR: ignored.
- Readback (SHIFT_EN=1, MODE=1): chain <= {chain[WIDTH-2:0], chain[WIDTH-1]}.
  - Allowed in IDLE and READY only; ignored in LOADING/ERROR.
  - Does not change BIT_CNT, parity, state or shadow.
  - WIDTH rotations restore the original chain.
- COMMIT:
  - In READY: shadow <= chain; BIT_CNT=0; parity=0; state=IDLE. MEM updates the cycle after the edge (if CFG_EN=1).
  - In other states: ignored.
  - With SHIFT_EN in the same cycle in READY: commit happens, shift dropped.
- CLR: BIT_CNT=0, parity=0, state=IDLE. Chain and shadow unchanged. CLR is the only exit from ERROR besides RST.
- CFG_EN is purely combinational on MEM/MEMB. It never affects chain, shadow or the FSM.
- RST mid-load: everything returns to reset values, including shadow. MEM drops to 0 on the next edge.
- BIT_CNT saturates at WIDTH+PARITY; it never wraps.

Decomposition:
- Package rs_ccff_pkg: state enum (IDLE=2'd0, LOADING=2'd1, READY=2'd2, ERROR=2'd3) and a function for the CNT_W calculation.
- Sub-module rs_ccff_out_cell: one-bit MEM/MEMB gating slice (shadow bit AND CFG_EN, plus inverter), instantiated WIDTH times in a generate loop.
- FSM, counter, chain and shadow stay in the top module.

Test Plan:
- Load and commit: WIDTH=8, PARITY=1, CFG_EN=1. Shift 1,0,1,0,0,1,0,1 then parity 0, then COMMIT -> DONE=1 before COMMIT; after COMMIT MEM=8'hA5, MEMB=8'h5A, BIT_CNT=0, state IDLE.
- CFG_EN gating: with shadow=8'hA5, drop CFG_EN to 0 -> MEM=8'h00, MEMB=8'hFF in the same cycle; restore CFG_EN=1 -> MEM=8'hA5.
- Bad parity: shift 8'hA5 data with parity bit 1 -> ERR=1; COMMIT -> MEM unchanged; CLR -> ERR=0, BIT_CNT=0.
- Overrun and priority: in READY, pulse SHIFT_EN alone -> ERR=1. Repeat the load; in READY assert COMMIT+SHIFT_EN together -> commit succeeds, chain not shifted.
- Readback: chain=8'hA5 in IDLE, 8 rotate shifts -> Q sequence 1,0,1,0,0,1,0,1 and chain back to 8'hA5; shadow and BIT_CNT unchanged.
- Reset mid-load: after 3 shifts assert RST -> BIT_CNT=0, Q=0, MEM=0, MEMB=8'hFF, DONE=ERR=0.

Source files
------------

// File: rtl/rs_ccff_pkg.sv
// rs_ccff_pkg: shared state encoding and counter sizing for the configuration-chain segment
package rs_ccff_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2,
        ERROR   = 2'd3
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/rs_ccff_out_cell.sv
// rs_ccff_out_cell: one-bit MEM/MEMB slice, shadow bit gated by CFG_EN plus its complement
module rs_ccff_out_cell (
    input  logic i_shadow,
    input  logic i_cfg_en,
    output logic o_mem,
    output logic o_memb
);

    logic w_mem;

    assign w_mem  = i_shadow & i_cfg_en;
    assign o_mem  = w_mem;
    assign o_memb = ~w_mem;

endmodule

// File: rtl/rs_ccff_chain.sv
// rs_ccff_chain: WIDTH-bit serial configuration segment with parity check, shadow commit
// and non-destructive rotate readback
module rs_ccff_chain
    import rs_ccff_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit PARITY = 1'b1,
    parameter int CNT_W  = cnt_width(WIDTH)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             CFG_EN,
    input  logic             D,
    input  logic             SHIFT_EN,
    input  logic             MODE,
    input  logic             COMMIT,
    input  logic             CLR,
    output logic             Q,
    output logic [WIDTH-1:0] MEM,
    output logic [WIDTH-1:0] MEMB,
    output logic [CNT_W-1:0] BIT_CNT,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_chain;
    logic [WIDTH-1:0] r_shadow;
    logic [CNT_W-1:0] r_cnt;
    logic             r_par;
    state_t           r_state;

    always_ff @(posedge CK) begin
        if (RST) begin
            r_chain  <= '0;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_par    <= 1'b0;
            r_state  <= IDLE;
        end else if (CLR) begin
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_state <= IDLE;
        end else if (COMMIT) begin
            // COMMIT owns the cycle even when it is not in READY, so a shift never sneaks in
            if (r_state == READY) begin
                r_shadow <= r_chain;
                r_cnt    <= '0;
                r_par    <= 1'b0;
                r_state  <= IDLE;
            end
        end else if (SHIFT_EN) begin
            if (MODE) begin
                if (r_state == IDLE || r_state == READY)
                    r_chain <= {r_chain[WIDTH-2:0], r_chain[WIDTH-1]};
            end else begin
                case (r_state)
                    IDLE, LOADING: begin
                        if (r_cnt < CNT_FULL) begin
                            r_chain <= {r_chain[WIDTH-2:0], D};
                            r_par   <= r_par ^ D;
                            r_cnt   <= r_cnt + CNT_ONE;
                            r_state <= (!PARITY && r_cnt == CNT_FULL - CNT_ONE) ? READY : LOADING;
                        end else if (PARITY) begin
                            // trailing parity bit: checked, never shifted into the chain
                            r_cnt   <= CNT_FULL + CNT_ONE;
                            r_state <= (r_par ^ D) ? ERROR : READY;
                        end
                    end
                    READY:   r_state <= ERROR;
                    default: ;
                endcase
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_out
            rs_ccff_out_cell u_cell (
                .i_shadow (r_shadow[g]),
                .i_cfg_en (CFG_EN),
                .o_mem    (MEM[g]),
                .o_memb   (MEMB[g])
            );
        end
    endgenerate

    assign Q       = r_chain[WIDTH-1];
    assign BIT_CNT = r_cnt;
    assign DONE    = (r_state == READY);
    assign ERR     = (r_state == ERROR);

endmodule
